// File: rtl/bus_xfer_seq.sv
// Single-source, single-destination register transfer sequencer.
// Drives the bus select, pulses one load enable and counts completed transfers.
module bus_xfer_seq #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 24,
  parameter int RO_CODE = 22
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         src_sel,
  input  logic [4:0]         dst_sel,
  input  logic [DATA_W-1:0]  bus_in,
  output logic [4:0]         read,
  output logic [NUM_SRC-1:0] load_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  xfer_data,
  output logic [7:0]         xfer_count
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam logic [4:0] READ_NONE = 5'd31;

  state_t              state, state_d;
  logic [4:0]          src_q, dst_q, src_d, dst_d;
  logic [4:0]          read_d;
  logic [NUM_SRC-1:0]  load_en_d;
  logic                busy_d, done_d, err_d;
  logic [DATA_W-1:0]   xfer_data_d;
  logic [7:0]          xfer_count_d;
  logic                req_valid;

  assign req_valid = ({1'b0, src_sel} < 6'(NUM_SRC)) &&
                     ({1'b0, dst_sel} < 6'(NUM_SRC)) &&
                     ({1'b0, dst_sel} != 6'(RO_CODE));

  // NOTE: every output is computed from the next state and registered below, so
  // outputs are glitch-free and line up with the state they describe.
  always_comb begin
    state_d      = state;
    src_d        = src_q;
    dst_d        = dst_q;
    read_d       = READ_NONE;
    load_en_d    = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    xfer_data_d  = xfer_data;
    xfer_count_d = xfer_count;

    unique case (state)
      IDLE: begin
        if (start) begin
          src_d   = src_sel;
          dst_d   = dst_sel;
          state_d = req_valid ? SELECT : ERR;
        end
      end
      SELECT:  state_d = LOAD;
      LOAD: begin
        state_d      = DONE;
        xfer_data_d  = bus_in;
        xfer_count_d = xfer_count + 8'd1;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      SELECT: begin
        read_d = src_d;
        busy_d = 1'b1;
      end
      LOAD: begin
        read_d = src_q;
        busy_d = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
          load_en_d[i] = (dst_q == 5'(i));
        end
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      ERR:     err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      read       <= READ_NONE;
      load_en    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      xfer_data  <= '0;
      xfer_count <= '0;
    end else begin
      state      <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      read       <= read_d;
      load_en    <= load_en_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      xfer_data  <= xfer_data_d;
      xfer_count <= xfer_count_d;
    end
  end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq: cycle-by-cycle vector table plus
// hand-written sequences for mid-transfer clear and counter wrap.
module tb_bus_xfer_seq;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 24;
  localparam int RO_CODE = 22;

  logic               clk = 1'b0;
  logic               clear, start;
  logic [4:0]         src_sel, dst_sel;
  logic [DATA_W-1:0]  bus_in;
  logic [4:0]         read;
  logic [NUM_SRC-1:0] load_en;
  logic               busy, done, err;
  logic [DATA_W-1:0]  xfer_data;
  logic [7:0]         xfer_count;

  bus_xfer_seq #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .RO_CODE(RO_CODE)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .src_sel    (src_sel),
    .dst_sel    (dst_sel),
    .bus_in     (bus_in),
    .read       (read),
    .load_en    (load_en),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .xfer_data  (xfer_data),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        start;
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [31:0] bus;
    logic [4:0]  read;
    logic [23:0] le;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] data;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] outs();
    return {read, load_en, busy, done, err, xfer_data, xfer_count};
  endfunction

  function automatic vec_t mk(input logic s, input logic [4:0] sr, input logic [4:0] ds,
                              input logic [31:0] b, input logic [4:0] rd, input logic [23:0] le,
                              input logic bz, input logic dn, input logic er,
                              input logic [31:0] dt, input logic [7:0] ct);
    vec_t v;
    v = '{start:s, src:sr, dst:ds, bus:b, read:rd, le:le, busy:bz, done:dn, err:er, data:dt, cnt:ct};
    return v;
  endfunction

  initial begin
    int pulses;
    int bad;
    logic [4:0] d;

    // Row: inputs applied before the edge, outputs expected just after it.
    tbl.push_back(mk(1,  3,  7, 32'hDEADBEEF,  3, 24'h000000, 1, 0, 0, 32'h00000000, 0)); // SELECT
    tbl.push_back(mk(0,  0,  0, 32'hDEADBEEF,  3, 24'h000080, 1, 0, 0, 32'h00000000, 0)); // LOAD, sel change ignored
    tbl.push_back(mk(0,  0,  0, 32'hDEADBEEF, 31, 24'h000000, 1, 1, 0, 32'hDEADBEEF, 1)); // DONE
    tbl.push_back(mk(0,  0,  0, 32'h00000000, 31, 24'h000000, 0, 0, 0, 32'hDEADBEEF, 1)); // IDLE
    tbl.push_back(mk(1,  5, 22, 32'h00000000, 31, 24'h000000, 0, 0, 1, 32'hDEADBEEF, 1)); // dst read-only
    tbl.push_back(mk(1, 24,  1, 32'h00000000, 31, 24'h000000, 0, 0, 0, 32'hDEADBEEF, 1)); // start ignored in ERR
    tbl.push_back(mk(1, 24,  1, 32'h00000000, 31, 24'h000000, 0, 0, 1, 32'hDEADBEEF, 1)); // src out of range
    tbl.push_back(mk(0,  0,  0, 32'h00000000, 31, 24'h000000, 0, 0, 0, 32'hDEADBEEF, 1));
    tbl.push_back(mk(1,  2, 31, 32'h00000000, 31, 24'h000000, 0, 0, 1, 32'hDEADBEEF, 1)); // dst out of range
    tbl.push_back(mk(0,  0,  0, 32'h00000000, 31, 24'h000000, 0, 0, 0, 32'hDEADBEEF, 1));
    tbl.push_back(mk(1,  9,  9, 32'h12345678,  9, 24'h000000, 1, 0, 0, 32'hDEADBEEF, 1)); // src == dst
    tbl.push_back(mk(0,  0,  0, 32'h12345678,  9, 24'h000200, 1, 0, 0, 32'hDEADBEEF, 1));
    tbl.push_back(mk(1,  1,  2, 32'h12345678, 31, 24'h000000, 1, 1, 0, 32'h12345678, 2)); // start in LOAD
    tbl.push_back(mk(1,  1,  2, 32'h00000000, 31, 24'h000000, 0, 0, 0, 32'h12345678, 2)); // start in DONE
    tbl.push_back(mk(0,  0,  0, 32'h00000000, 31, 24'h000000, 0, 0, 0, 32'h12345678, 2)); // no 2nd xfer
    tbl.push_back(mk(1, 23,  0, 32'hA5A5A5A5, 23, 24'h000000, 1, 0, 0, 32'h12345678, 2)); // edge codes
    tbl.push_back(mk(0,  0,  0, 32'hA5A5A5A5, 23, 24'h000001, 1, 0, 0, 32'h12345678, 2));
    tbl.push_back(mk(0,  0,  0, 32'hA5A5A5A5, 31, 24'h000000, 1, 1, 0, 32'hA5A5A5A5, 3));
    tbl.push_back(mk(1,  0, 23, 32'h00000000, 31, 24'h000000, 0, 0, 0, 32'hA5A5A5A5, 3));
    tbl.push_back(mk(1,  0, 23, 32'hFFFFFFFF,  0, 24'h000000, 1, 0, 0, 32'hA5A5A5A5, 3)); // accepted at k+4
    tbl.push_back(mk(0,  0,  0, 32'hFFFFFFFF,  0, 24'h800000, 1, 0, 0, 32'hA5A5A5A5, 3));
    tbl.push_back(mk(0,  0,  0, 32'hFFFFFFFF, 31, 24'h000000, 1, 1, 0, 32'hFFFFFFFF, 4));
    tbl.push_back(mk(0,  0,  0, 32'h00000000, 31, 24'h000000, 0, 0, 0, 32'hFFFFFFFF, 4));

    clear = 1'b1; start = 1'b0; src_sel = '0; dst_sel = '0; bus_in = '0;
    step();
    step();
    check("reset", outs(), {5'd31, 24'h0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0});
    clear = 1'b0;

    foreach (tbl[i]) begin
      start = tbl[i].start; src_sel = tbl[i].src; dst_sel = tbl[i].dst; bus_in = tbl[i].bus;
      step();
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].read, tbl[i].le, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].data, tbl[i].cnt});
    end

    // Clear during LOAD aborts the transfer with no further load or done.
    start = 1'b1; src_sel = 5'd4; dst_sel = 5'd5; bus_in = 32'h0BADF00D;
    step();
    start = 1'b0;
    step();
    check("midclr_load", load_en, 24'h000020);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("midclr_idle", outs(), {5'd31, 24'h0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0});
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done !== 1'b0 || load_en !== '0 || busy !== 1'b0) bad++;
    end
    check("midclr_quiet", bad, 0);

    // Clear wins over a simultaneous valid start.
    clear = 1'b1; start = 1'b1; src_sel = 5'd1; dst_sel = 5'd2;
    step();
    clear = 1'b0; start = 1'b0;
    step();
    check("clr_prio", {busy, read, load_en}, {1'b0, 5'd31, 24'h0});

    // 256 back-to-back transfers wrap the counter.
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      d = 5'(i % 22);
      start = 1'b1; src_sel = 5'(i % 24); dst_sel = d; bus_in = 32'(i) * 32'h01010101;
      step();
      start = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
        if ($countones(load_en) > 1) bad++;
        if (load_en != '0) begin
          pulses++;
          if (load_en !== (24'd1 << d)) bad++;
        end
        if (c < 3) step();
      end
      if (pulses != 1) bad++;
      if (i == 254) check("count_255", xfer_count, 8'd255);
    end
    check("wrap_pulses", bad, 0);
    check("wrap_count", xfer_count, 8'd0);
    check("wrap_data", xfer_data, 32'hFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_xfer_seq.md
BUS_XFER_SEQ -- requirements
Module: bus_xfer_seq

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the bus data width.
REQ-002 The module SHALL have parameter NUM_SRC, default 24, giving the number of valid bus source/destination codes (0..NUM_SRC-1).
REQ-003 The module SHALL have parameter RO_CODE, default 22, giving the input-port code, which is read-only as a destination.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset: clock input 1, system clock, all state updates on its rising edge.
REQ-005 The module SHALL have port clear: input, 1 bit, synchronous active-high reset.
REQ-006 The module SHALL have port start: input, 1 bit, transfer request, sampled only in IDLE.
REQ-007 The module SHALL have port src_sel: input, 5 bits, source register code.
REQ-008 The module SHALL have port dst_sel: input, 5 bits, destination register code.
REQ-009 The module SHALL have port bus_in: input, DATA_W bits, bus value returned from the bus multiplexer.
REQ-010 The module SHALL have port read: output, 5 bits, select code driven to the bus multiplexer.
REQ-011 The module SHALL have port load_en: output, NUM_SRC bits, one-hot register load enables.
REQ-012 The module SHALL have port busy: output, 1 bit, high while a transfer is in flight.
REQ-013 The module SHALL have port done: output, 1 bit, one-cycle completion pulse.
REQ-014 The module SHALL have port err: output, 1 bit, one-cycle rejected-request pulse.
REQ-015 The module SHALL have port xfer_data: output, DATA_W bits, last value captured from bus_in.
REQ-016 The module SHALL have port xfer_count: output, 8 bits, count of completed transfers.

Function
REQ-017 The FSM SHALL have states IDLE, SELECT, LOAD, DONE and ERR, with all outputs registered.
REQ-018 In IDLE, a start=1 request SHALL latch src_sel and dst_sel and go to SELECT if the request is valid, or to ERR otherwise.
REQ-019 A request SHALL be invalid if any of the following holds: src_sel>=NUM_SRC; dst_sel>=NUM_SRC; dst_sel==RO_CODE.
REQ-020 SELECT SHALL drive read=latched src for one cycle (mux settle time) and then go to LOAD.
REQ-021 LOAD SHALL hold read=src, drive load_en[dst]=1 with all other bits 0, capture bus_in into xfer_data at the exiting edge, and go to DONE.
REQ-022 DONE SHALL drive done=1, read=31, and load_en=0, increment xfer_count (modulo 256, 255 wraps to 0), and go to IDLE.
REQ-023 ERR SHALL drive err=1 for exactly one cycle, leave read, load_en, xfer_data and xfer_count unchanged, and go to IDLE.
REQ-024 busy SHALL be 1 in SELECT, LOAD and DONE, and 0 in IDLE and ERR.
REQ-025 In IDLE and ERR, read SHALL be 31 (out-of-range code, so the bus reads zero) and load_en SHALL be 0.
REQ-026 Latency: with start sampled at edge k, read is valid from cycle k+1, load_en is high in cycle k+2 only, done is high in cycle k+3, and the next start is accepted at edge k+4.
REQ-027 start SHALL be ignored outside IDLE; src_sel and dst_sel changes after acceptance SHALL have no effect.
REQ-028 src==dst SHALL be a legal transfer (register reloads its own value).
REQ-029 load_en SHALL never have more than one bit set in any cycle.

Reset
REQ-030 clear=1 at a rising edge SHALL force: IDLE, read=31, load_en=0, busy=0, done=0, err=0, xfer_data=0, xfer_count=0.
REQ-031 clear SHALL take priority over start and over any in-flight state; a transfer aborted by clear SHALL produce no load_en pulse after the clearing edge.

Verification
REQ-032 Reset: assert clear for 2 cycles -> read=31, load_en=0, xfer_count=0, busy=0.
REQ-033 Basic transfer: start, src=3, dst=7, bus_in=0xDEADBEEF -> read=3 for 2 cycles, then load_en=0x000080 for 1 cycle, then done=1, xfer_data=0xDEADBEEF, xfer_count=1.
REQ-034 Invalid request: start with dst=22, then start with src=24 -> err=1 for one cycle each, load_en stays 0, xfer_count unchanged.
REQ-035 Busy ignore: start while in LOAD with src=1, dst=2 -> original transfer completes unaffected, and no second transfer occurs.
REQ-036 Mid-operation reset: clear asserted in LOAD cycle -> next cycle state is IDLE, load_en=0, done is never pulsed.
REQ-037 Counter wrap: 256 back-to-back valid transfers -> xfer_count returns to 0, and each transfer shows exactly one load_en pulse.
